planificador_simd: RTL and testbench
====================================

PLANIFICADOR_SIMD -- requirements
Module: planificador_simd

Interface
REQ-001 SHALL have parameter N, default 4, number of SIMD lanes per group.
REQ-002 SHALL have parameter W, default 16, width of image dimensions and integer coordinates.
REQ-003 SHALL have a single clock and an asynchronous active-low reset: clk and rst_n.
REQ-004 SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- inicio  in  1  start pulse; sampled only in IDLE.
- abortar  in  1  returns the block to IDLE on the next edge, from any state.
- ancho_dst, alto_dst  in  W  output image size; both >= 1.
- ancho_src, alto_src  in  W  source image size; both >= 2.
- escala_x, escala_y  in  q8_8_t  source step per output pixel.
- fetch_req  out  1  group request to the pixel fetch unit.
- fetch_ack  in  1  one-cycle pulse: pixels for the current group are ready.
- cargar  out  1  one-cycle load strobe to the SIMD register bank.
- dp_listo  in  1  one-cycle pulse: datapath has consumed the group.
- x0, x1  out  W x [N]  per-lane source columns.
- y0, y1  out  W  source rows, shared by all lanes.
- fx_out  out  q8_8_t x [N]  per-lane horizontal fraction.
- fy_out  out  q8_8_t  vertical fraction.
- lane_valida  out  [N]  lane mask.
- ocupado  out  1  high in every state except IDLE.
- fin  out  1  one-cycle pulse when the last group completes.

Function
REQ-005 SHALL implement the FSM states IDLE, CALC, FETCH, LOAD, WAIT.
- IDLE -> CALC on inicio; register dims and scales, ox = 0, oy = 0.
- CALC -> FETCH after 1 cycle; compute coordinates for the current group.
- FETCH -> LOAD on fetch_ack.
- LOAD -> WAIT unconditionally.
- WAIT -> CALC on dp_listo with groups remaining.
- WAIT -> IDLE on dp_listo after the last group.
REQ-006 SHALL form a group from output pixels (ox+k, oy), k = 0..N-1, where lane k is valid iff ox+k < ancho_dst.
REQ-007 SHALL compute position px = (ox+k)*escala_x as unsigned Q(W).8 without overflow loss.
REQ-008 SHALL derive x0 = min(px integer part, ancho_src-1), x1 = min(x0+1, ancho_src-1), and fx_out = {8'h00, px[7:0]}.
REQ-009 SHALL derive y0, y1 and fy_out from oy*escala_y using the same rules against alto_src.
REQ-010 SHALL drive x0, x1, y0, y1, fx_out and fy_out to 0 for invalid lanes.
REQ-011 SHALL hold all coordinate outputs and lane_valida stable from CALC exit until WAIT exit.
REQ-012 SHALL assert fetch_req throughout FETCH only, and ignore fetch_ack outside FETCH.
REQ-013 SHALL assert cargar for exactly the single LOAD cycle, and ignore dp_listo outside WAIT.
REQ-014 SHALL advance on WAIT exit as follows: ox += N; if ox >= ancho_dst then ox = 0 and oy += 1; the last group is the one with oy = alto_dst-1 and ox+N >= ancho_dst.
REQ-015 SHALL assert fin together with the WAIT -> IDLE transition edge, i.e. during the final dp_listo cycle.
REQ-016 SHALL ignore inicio while ocupado is high.
REQ-017 SHALL give abortar priority over all transitions: next state IDLE, no fin, cargar and fetch_req low.
REQ-018 SHALL have a minimum per-group latency, inicio to first cargar, of 3 cycles when fetch_ack arrives in the first FETCH cycle.

Reset
REQ-019 SHALL on rst_n low asynchronously set state IDLE, ox = oy = 0, and all outputs to 0, including lane_valida = 0 and ocupado = 0.
REQ-020 SHALL, on reset asserted mid-frame, discard the frame; after release the block waits for a new inicio.

Verification
REQ-021 SHALL be verified with a bench covering at least these scenarios:
- 2x downscale: ancho_dst = 4, alto_dst = 2, ancho_src = 8, alto_src = 4, escala = 0x0200 -> 2 cargar pulses; group 0 x0 = {0,2,4,6}, fx = 0; row 1 y0 = 2; fin once.
- Fractional scale: escala_x = 0x0180, ancho_dst = 4 -> x0 = {0,1,3,4}, fx_out = {0x00,0x80,0x00,0x80}.
- Partial group: ancho_dst = 6, N = 4 -> second group lane_valida = 0011, lanes 2-3 all zero; 2 groups per row.
- Edge clamp: ancho_src = 4, escala_x = 0x0100, ancho_dst = 4 -> lane 3 x0 = 3, x1 = 3.
- Handshake stall: fetch_ack delayed 5 cycles and dp_listo delayed 3 cycles -> outputs stable, single cargar, fetch_req high exactly 5 cycles; spurious fetch_ack/dp_listo in IDLE ignored.
- Abort and reset mid-frame: abortar, then separately rst_n low in WAIT -> IDLE next edge, no fin, outputs 0; a new inicio restarts at ox = oy = 0.

Source files
------------

// File: rtl/planificador_simd_if.sv
// Signal bundle between the SIMD group scheduler and its surroundings (control, fetch unit, register bank).
interface planificador_simd_if #(
  parameter int N = 4,
  parameter int W = 16
);
  typedef logic [15:0] q8_8_t;

  logic               inicio;
  logic               abortar;
  logic [W-1:0]       ancho_dst;
  logic [W-1:0]       alto_dst;
  logic [W-1:0]       ancho_src;
  logic [W-1:0]       alto_src;
  q8_8_t              escala_x;
  q8_8_t              escala_y;
  // fetch_req is held for the whole FETCH state; fetch_ack and dp_listo are single-cycle
  // pulses that only count in FETCH and WAIT respectively.
  logic               fetch_req;
  logic               fetch_ack;
  logic               cargar;
  logic               dp_listo;
  logic [N-1:0][W-1:0]  x0;
  logic [N-1:0][W-1:0]  x1;
  logic [W-1:0]       y0;
  logic [W-1:0]       y1;
  logic [N-1:0][15:0] fx_out;
  q8_8_t              fy_out;
  logic [N-1:0]       lane_valida;
  logic               ocupado;
  logic               fin;

  modport master (
    output inicio, abortar, ancho_dst, alto_dst, ancho_src, alto_src,
           escala_x, escala_y, fetch_ack, dp_listo,
    input  fetch_req, cargar, x0, x1, y0, y1, fx_out, fy_out,
           lane_valida, ocupado, fin
  );

  modport slave (
    input  inicio, abortar, ancho_dst, alto_dst, ancho_src, alto_src,
           escala_x, escala_y, fetch_ack, dp_listo,
    output fetch_req, cargar, x0, x1, y0, y1, fx_out, fy_out,
           lane_valida, ocupado, fin
  );
endinterface

// File: rtl/planificador_simd.sv
// Walks the output image in groups of N pixels and emits clamped bilinear source
// coordinates per group, sequencing the fetch unit and the SIMD register load.
module planificador_simd #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  planificador_simd_if.slave bus,
  output logic [2:0]         estado
);
  localparam int CW = W + 1;   // ox+k may exceed ancho_dst by up to N-1
  localparam int PW = CW + 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t state, state_d;

  logic [W-1:0]        ancho_dst_q, alto_dst_q, ancho_src_q, alto_src_q;
  logic [15:0]         esc_x_q, esc_y_q;
  logic [W-1:0]        ox, oy;
  logic [N-1:0][W-1:0] x0_q, x1_q, x0_c, x1_c;
  logic [N-1:0][15:0]  fx_q, fx_c;
  logic [N-1:0]        valid_q, valid_c;
  logic [W-1:0]        y0_q, y1_q, y0_c, y1_c;
  logic [15:0]         fy_q, fy_c;
  logic [CW-1:0]       col, nxt_ox;
  logic [PW-1:0]       px, py;
  logic                wrap, last;

  function automatic logic [W-1:0] clamp_int(input logic [PW-9:0] ip, input logic [W-1:0] lim);
    return (ip > (PW-8)'(lim)) ? lim : ip[W-1:0];
  endfunction

  function automatic logic [W-1:0] next_up(input logic [W-1:0] c, input logic [W-1:0] lim);
    return (c < lim) ? c + W'(1) : lim;
  endfunction

  always_comb begin
    x0_c    = '0;
    x1_c    = '0;
    fx_c    = '0;
    valid_c = '0;
    col     = '0;
    px      = '0;
    for (int k = 0; k < N; k++) begin
      col = CW'(ox) + CW'(k);
      px  = PW'(col) * PW'(esc_x_q);
      if (col < CW'(ancho_dst_q)) begin
        valid_c[k] = 1'b1;
        x0_c[k]    = clamp_int(px[PW-1:8], ancho_src_q - W'(1));
        x1_c[k]    = next_up(x0_c[k], ancho_src_q - W'(1));
        fx_c[k]    = {8'h00, px[7:0]};
      end
    end
  end

  always_comb begin
    py   = PW'(oy) * PW'(esc_y_q);
    y0_c = clamp_int(py[PW-1:8], alto_src_q - W'(1));
    y1_c = next_up(y0_c, alto_src_q - W'(1));
    fy_c = {8'h00, py[7:0]};
  end

  assign nxt_ox = CW'(ox) + CW'(N);
  assign wrap   = nxt_ox >= CW'(ancho_dst_q);
  assign last   = wrap && (oy == alto_dst_q - W'(1));

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.inicio) state_d = CALC;
      CALC:    state_d = FETCH;
      FETCH:   if (bus.fetch_ack) state_d = LOAD;
      LOAD:    state_d = WAIT;
      WAIT:    if (bus.dp_listo) state_d = last ? IDLE : CALC;
      default: state_d = IDLE;
    endcase
    if (bus.abortar) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ancho_dst_q <= '0;
      alto_dst_q  <= '0;
      ancho_src_q <= '0;
      alto_src_q  <= '0;
      esc_x_q     <= '0;
      esc_y_q     <= '0;
      ox          <= '0;
      oy          <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      fx_q        <= '0;
      valid_q     <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      fy_q        <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && state_d == CALC) begin
        ancho_dst_q <= bus.ancho_dst;
        alto_dst_q  <= bus.alto_dst;
        ancho_src_q <= bus.ancho_src;
        alto_src_q  <= bus.alto_src;
        esc_x_q     <= bus.escala_x;
        esc_y_q     <= bus.escala_y;
      end
      if (state == WAIT && state_d == CALC) begin
        if (wrap) begin
          ox <= '0;
          oy <= oy + W'(1);
        end else begin
          ox <= nxt_ox[W-1:0];
        end
      end
      // Coordinates are captured on CALC exit and held until the group retires.
      if (state_d == IDLE) begin
        ox      <= '0;
        oy      <= '0;
        x0_q    <= '0;
        x1_q    <= '0;
        fx_q    <= '0;
        valid_q <= '0;
        y0_q    <= '0;
        y1_q    <= '0;
        fy_q    <= '0;
      end else if (state == CALC) begin
        x0_q    <= x0_c;
        x1_q    <= x1_c;
        fx_q    <= fx_c;
        valid_q <= valid_c;
        y0_q    <= y0_c;
        y1_q    <= y1_c;
        fy_q    <= fy_c;
      end
    end
  end

  assign bus.fetch_req   = (state == FETCH) && !bus.abortar;
  assign bus.cargar      = (state == LOAD) && !bus.abortar;
  assign bus.fin         = (state == WAIT) && bus.dp_listo && last && !bus.abortar;
  assign bus.ocupado     = (state != IDLE);
  assign bus.x0          = x0_q;
  assign bus.x1          = x1_q;
  assign bus.fx_out      = fx_q;
  assign bus.lane_valida = valid_q;
  assign bus.y0          = y0_q;
  assign bus.y1          = y1_q;
  assign bus.fy_out      = fy_q;
  assign estado          = state;
endmodule

// File: tb/tb_planificador_simd.sv
// Bench for planificador_simd: directed and random frames against a per-group
// coordinate model, plus handshake stalls, abort and mid-frame reset.
module tb_planificador_simd;
  localparam int N = 4;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] estado;
  int         n_checks = 0;
  int         n_fail = 0;

  planificador_simd_if #(.N(N), .W(W)) bus ();

  planificador_simd #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .estado (estado)
  );

  always #5 clk = ~clk;

  logic [N*W-1:0]  obs_x0, obs_x1;
  logic [N*16-1:0] obs_fx;
  assign obs_x0 = bus.x0;
  assign obs_x1 = bus.x1;
  assign obs_fx = bus.fx_out;

  typedef struct {
    logic [N*W-1:0]  x0;
    logic [N*W-1:0]  x1;
    logic [W-1:0]    y0;
    logic [W-1:0]    y1;
    logic [N*16-1:0] fx;
    logic [15:0]     fy;
    logic [N-1:0]    v;
    bit              last;
  } grp_t;

  grp_t exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grp(input string tag, input grp_t g);
    chk({tag, ".x0"}, 128'(obs_x0), 128'(g.x0));
    chk({tag, ".x1"}, 128'(obs_x1), 128'(g.x1));
    chk({tag, ".fx"}, 128'(obs_fx), 128'(g.fx));
    chk({tag, ".y"}, 128'({bus.y0, bus.y1, bus.fy_out}), 128'({g.y0, g.y1, g.fy}));
    chk({tag, ".lanes"}, 128'(bus.lane_valida), 128'(g.v));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ctrl"}, 128'({bus.ocupado, bus.fin, bus.fetch_req, bus.cargar}), 128'(0));
    chk({tag, ".lanes"}, 128'(bus.lane_valida), 128'(0));
    chk({tag, ".xs"}, 128'({obs_x0, obs_x1}), 128'(0));
    chk({tag, ".rest"}, 128'({obs_fx, bus.y0, bus.y1, bus.fy_out}), 128'(0));
  endtask

  // Expected groups in raster order, computed with plain integer arithmetic.
  task automatic build(input int ad, input int al, input int as_, input int als,
                       input int ex, input int ey);
    grp_t   g;
    longint p, ip, c;
    exp_q.delete();
    for (int oy = 0; oy < al; oy++) begin
      for (int ox = 0; ox < ad; ox += N) begin
        g.x0 = '0; g.x1 = '0; g.fx = '0; g.v = '0;
        p  = longint'(oy) * ey;
        ip = p / 256;
        c  = (ip > als - 1) ? als - 1 : ip;
        g.y0 = W'(c);
        g.y1 = W'((c + 1 > als - 1) ? als - 1 : c + 1);
        g.fy = 16'(p % 256);
        for (int k = 0; k < N; k++) begin
          if (ox + k < ad) begin
            p  = longint'(ox + k) * ex;
            ip = p / 256;
            c  = (ip > as_ - 1) ? as_ - 1 : ip;
            g.v[k] = 1'b1;
            g.x0[k*W +: W]   = W'(c);
            g.x1[k*W +: W]   = W'((c + 1 > as_ - 1) ? as_ - 1 : c + 1);
            g.fx[k*16 +: 16] = 16'(p % 256);
          end
        end
        g.last = (oy == al - 1) && (ox + N >= ad);
        exp_q.push_back(g);
      end
    end
  endtask

  task automatic set_cfg(input int ad, input int al, input int as_, input int als,
                         input int ex, input int ey);
    bus.ancho_dst = W'(ad);
    bus.alto_dst  = W'(al);
    bus.ancho_src = W'(as_);
    bus.alto_src  = W'(als);
    bus.escala_x  = 16'(ex);
    bus.escala_y  = 16'(ey);
  endtask

  task automatic run_frame(input string tag, input int ad, input int al, input int as_,
                           input int als, input int ex, input int ey,
                           input int fd_min, input int fd_max, input int dd_min, input int dd_max);
    grp_t g;
    int   d, e, hi, ngrp;
    int   n_load = 0;
    int   n_fin = 0;
    build(ad, al, as_, als, ex, ey);
    ngrp = exp_q.size();
    set_cfg(ad, al, as_, als, ex, ey);
    bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    while (exp_q.size() > 0) begin
      g = exp_q.pop_front();
      chk({tag, ".calc_ctrl"}, 128'({bus.ocupado, bus.fetch_req, bus.cargar}), 128'(3'b100));
      @(negedge clk);
      chk_grp({tag, ".fetch"}, g);
      d  = $urandom_range(fd_max, fd_min);
      hi = 0;
      for (int i = 0; i < d; i++) begin
        if (bus.fetch_req) hi++;
        chk({tag, ".fetch_stall_cargar"}, 128'(bus.cargar), 128'(0));
        bus.inicio   = 1'($urandom_range(1, 0));
        bus.dp_listo = 1'($urandom_range(1, 0));
        @(negedge clk);
        chk_grp({tag, ".fetch_stable"}, g);
      end
      bus.inicio   = 1'b0;
      bus.dp_listo = 1'b0;
      if (bus.fetch_req) hi++;
      bus.fetch_ack = 1'b1;
      @(negedge clk);
      bus.fetch_ack = 1'b0;
      chk({tag, ".fetch_req_cycles"}, 128'(hi), 128'(d + 1));
      chk({tag, ".load_ctrl"}, 128'({bus.fetch_req, bus.cargar}), 128'(2'b01));
      if (bus.cargar) n_load++;
      @(negedge clk);
      e = $urandom_range(dd_max, dd_min);
      for (int i = 0; i < e; i++) begin
        chk({tag, ".wait_ctrl"}, 128'({bus.fetch_req, bus.cargar, bus.fin}), 128'(0));
        bus.fetch_ack = 1'($urandom_range(1, 0));
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        chk_grp({tag, ".wait_stable"}, g);
      end
      chk_grp({tag, ".wait_exit"}, g);
      bus.dp_listo = 1'b1;
      #1;
      chk({tag, ".fin"}, 128'(bus.fin), 128'(g.last));
      if (bus.fin) n_fin++;
      @(negedge clk);
      bus.dp_listo = 1'b0;
    end
    chk({tag, ".n_cargar"}, 128'(n_load), 128'(ngrp));
    chk({tag, ".n_fin"}, 128'(n_fin), 128'(1));
    chk_idle({tag, ".done"});
  endtask

  task automatic reach_wait(input string tag, input int ad, input int al, input int as_,
                            input int als, input int ex, input int ey);
    set_cfg(ad, al, as_, als, ex, ey);
    bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    @(negedge clk);
    bus.fetch_ack = 1'b1;
    @(negedge clk);
    bus.fetch_ack = 1'b0;
    @(negedge clk);
    chk({tag, ".in_wait"}, 128'({bus.ocupado, bus.cargar, bus.fetch_req}), 128'(3'b100));
  endtask

  initial begin
    bus.inicio    = 1'b0;
    bus.abortar   = 1'b0;
    bus.fetch_ack = 1'b0;
    bus.dp_listo  = 1'b0;
    set_cfg(4, 2, 8, 4, 'h200, 'h200);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    bus.fetch_ack = 1'b1;
    bus.dp_listo  = 1'b1;
    @(negedge clk);
    bus.fetch_ack = 1'b0;
    bus.dp_listo  = 1'b0;
    @(negedge clk);
    chk_idle("spurious_idle");

    run_frame("down2x",  4, 2, 8,  4, 'h200, 'h200, 0, 0, 0, 0);
    run_frame("frac",    4, 1, 8,  4, 'h180, 'h100, 0, 0, 0, 0);
    run_frame("partial", 6, 2, 16, 8, 'h100, 'h100, 0, 1, 0, 1);
    run_frame("clamp",   4, 3, 4,  2, 'h100, 'h100, 0, 0, 0, 0);
    run_frame("stall",   4, 2, 8,  4, 'h200, 'h200, 4, 4, 2, 2);
    for (int r = 0; r < 4; r++) begin
      run_frame("rand", $urandom_range(9, 1), $urandom_range(3, 1), $urandom_range(12, 2),
                $urandom_range(6, 2), $urandom_range(1023, 0), $urandom_range(1023, 0),
                0, 3, 0, 3);
    end

    // Abort in WAIT of a single-group frame while dp_listo would otherwise finish it.
    reach_wait("abort", 4, 1, 8, 4, 'h200, 'h200);
    bus.abortar  = 1'b1;
    bus.dp_listo = 1'b1;
    #1;
    chk("abort.no_fin", 128'({bus.fin, bus.cargar, bus.fetch_req}), 128'(0));
    @(negedge clk);
    bus.abortar  = 1'b0;
    bus.dp_listo = 1'b0;
    chk_idle("abort.idle");

    // Abort in FETCH with a simultaneous fetch_ack.
    set_cfg(6, 2, 8, 4, 'h100, 'h100);
    bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
    @(negedge clk);
    chk("abort_fetch.req", 128'(bus.fetch_req), 128'(1));
    bus.abortar   = 1'b1;
    bus.fetch_ack = 1'b1;
    #1;
    chk("abort_fetch.req_low", 128'(bus.fetch_req), 128'(0));
    @(negedge clk);
    bus.abortar   = 1'b0;
    bus.fetch_ack = 1'b0;
    chk_idle("abort_fetch.idle");

    reach_wait("rst", 4, 2, 8, 4, 'h200, 'h200);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rst.released");
    run_frame("restart", 4, 2, 8, 4, 'h200, 'h200, 0, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
